frv_mmio_bridge: RTL
====================

FRV_MMIO_BRIDGE -- requirements
Module: frv_mmio_bridge

Interface
REQ-001 SHALL have parameter MMIO_BASE_ADDR, default 32'h0000_1000, base address of the timer MMIO region.
REQ-002 SHALL have parameter MMIO_BASE_MASK, default 32'hFFFF_F000, mask selecting the region-compare address bits.
REQ-003 SHALL have port g_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port g_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_addr in 32, req_wen in 1, req_strb in 4, req_wdata in 32: core-side request channel.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_error out 1: core-side response channel.
REQ-007 SHALL have ports mmio_en out 1, mmio_wen out 1, mmio_addr out 32, mmio_wdata out 32: the counter-block MMIO command.
REQ-008 SHALL have ports mmio_rdata in 32 and mmio_error in 1: counter-block MMIO result, valid the cycle after mmio_en.

Function
REQ-009 SHALL implement states IDLE, ACC, WAIT, RD, RWAIT, WR, RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, and addr, wen, strb and wdata are latched.
REQ-011 SHALL decode a hit as (req_addr & MMIO_BASE_MASK)==(MMIO_BASE_ADDR & MMIO_BASE_MASK) with req_addr[1:0]==0.
REQ-012 SHALL, on a miss, go IDLE->RESP with rsp_error=1 and rsp_rdata=0, and issue no mmio_en.
REQ-013 SHALL, on a hit read or full-strobe write (strb=4'hF), go IDLE->ACC->WAIT->RESP; rsp_valid is first high 3 cycles after acceptance.
REQ-014 SHALL, on a write with strb=4'h0, go IDLE->RESP with rsp_error=0 and issue no mmio_en.
REQ-015 SHALL assert mmio_en for exactly one cycle in each of ACC, RD and WR, and hold mmio_en=0 in every other state.
REQ-016 SHALL drive mmio_wen=1 only in WR, and in ACC for a write; mmio_wen=0 whenever mmio_en=0.
REQ-017 SHALL drive mmio_addr and mmio_wdata from latched registers, stable across the whole transaction.
REQ-018 SHALL, in WAIT, capture mmio_error into rsp_error and mmio_rdata into rsp_rdata for reads (0 for writes).
REQ-019 SHALL ignore req_strb on reads and always return the full 32-bit word.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_error stable in RESP until rsp_ready=1, then return to IDLE on the next cycle.
REQ-021 SHALL NOT accept a new request in the cycle the response handshake completes; the earliest acceptance is the following cycle.

Reset
REQ-022 SHALL, while g_reset=1 at a clock edge, enter IDLE and clear all latched request and response registers.
REQ-023 SHALL have these output values after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mmio_en=0, mmio_wen=0, mmio_addr=0, mmio_wdata=0.
REQ-024 SHALL, on a reset mid-transaction, discard the transaction: no response is produced and mmio_en=0 from the next cycle.

Configuration
REQ-025 SHALL use macro FRV_MMIO_SUBWORD_EN to select partial-write (strb not 0 and not F) handling.
REQ-026 SHALL, with the macro defined, perform read-modify-write on a partial write: IDLE->RD->RWAIT->WR->WAIT->RESP.
REQ-027 SHALL, with the macro defined, capture mmio_rdata in RWAIT and set each merged byte i to wdata byte i where strb[i]=1, else to the read byte.
REQ-028 SHALL, with the macro defined, go RWAIT->RESP with rsp_error=1 and skip WR if mmio_error=1 in RWAIT.
REQ-029 SHALL, with the macro undefined, go IDLE->RESP with rsp_error=1 on a partial write and issue no mmio_en.

Verification
REQ-030 SHALL cover: read at 0x1000 after reset -> one mmio_en pulse with wen=0 and addr 0x1000, rsp_valid 3 cycles after accept, rsp_rdata = mtime low word, rsp_error=0.
REQ-031 SHALL cover: write 0x1008 with strb F and data 0x0000_0010 -> single mmio_en pulse with wen=1 and wdata 0x0000_0010, rsp_error=0, rsp_rdata=0.
REQ-032 SHALL cover, with the macro defined: write 0x100C with strb 4'b0010 and data 0x0000_AB00, prior value 0xFFFF_FFFF -> read pulse, then write pulse with wdata 0xFFFF_ABFF; without the macro -> rsp_error=1 and no mmio_en.
REQ-033 SHALL cover: read at 0x2000 and read at 0x1002 -> rsp_error=1, mmio_en never asserted.
REQ-034 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stable throughout, req_ready=0 throughout.
REQ-035 SHALL cover: g_reset=1 during ACC -> next cycle IDLE, mmio_en=0, no rsp_valid, and a following read completes normally.

Source files
------------

// File: rtl/frv_mmio_bridge.sv
// Core-to-timer MMIO bridge: request/response channel to single-cycle MMIO command.
// Define FRV_MMIO_SUBWORD_EN to enable read-modify-write for partial-strobe writes.
module frv_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [3:0]  req_strb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mmio_en,
    output logic        mmio_wen,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_RD,
        S_RWAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic        r_mmio_en;
    logic        r_mmio_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wen;

    logic        w_accept;
    logic        w_hit;
    logic        w_full;
    logic        w_none;

    assign w_accept = req_valid && r_req_ready;
    assign w_hit    = ((req_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK))
                   && (req_addr[1:0] == 2'b00);
    assign w_full   = (req_strb == 4'hF);
    assign w_none   = (req_strb == 4'h0);

`ifdef FRV_MMIO_SUBWORD_EN
    logic [3:0]  r_strb;
    logic [31:0] w_merged;

    // Strobed bytes come from the new data, the rest from the value just read.
    always_comb begin
        w_merged = mmio_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_strb[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
            r_mmio_en   <= 1'b0;
            r_mmio_wen  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wen       <= 1'b0;
`ifdef FRV_MMIO_SUBWORD_EN
            r_strb      <= 4'h0;
`endif
        end else begin
            r_mmio_en  <= 1'b0;
            r_mmio_wen <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr;
                        r_wen       <= req_wen;
                        r_wdata     <= req_wdata;
`ifdef FRV_MMIO_SUBWORD_EN
                        r_strb      <= req_strb;
`endif
                        r_req_ready <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        if (!w_hit) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                        end else if (!req_wen || w_full) begin
                            r_state    <= S_ACC;
                            r_mmio_en  <= 1'b1;
                            r_mmio_wen <= req_wen;
                        end else if (w_none) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b0;
                        end else begin
`ifdef FRV_MMIO_SUBWORD_EN
                            r_state   <= S_RD;
                            r_mmio_en <= 1'b1;
`else
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
`endif
                        end
                    end
                end
                S_ACC: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= mmio_error;
                    r_rsp_rdata <= r_wen ? 32'h0 : mmio_rdata;
                end
                S_RD: begin
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
`ifdef FRV_MMIO_SUBWORD_EN
                    if (mmio_error) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end else begin
                        r_wdata    <= w_merged;
                        r_state    <= S_WR;
                        r_mmio_en  <= 1'b1;
                        r_mmio_wen <= 1'b1;
                    end
`else
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
`endif
                end
                S_WR: begin
                    r_state <= S_WAIT;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_error  = r_rsp_error;
    assign mmio_en    = r_mmio_en;
    assign mmio_wen   = r_mmio_wen;
    assign mmio_addr  = r_addr;
    assign mmio_wdata = r_wdata;

endmodule
